uart_program_loader: RTL

- Receives a program over the debug UART as a stream of bytes, assembles each group of bytes into instruction words and writes them sequentially into instruction memory.
- Stops loading on a HALT-opcode word or when memory is full.
- Returns a per-word acknowledge byte through the UART transmitter.
- Sits between the UART receiver/transmitter and the instruction memory write port inside TOP_MIPS, replacing the fixed 32-bit little-endian loader with a parametrised one that has byte-order, timeout and overflow handling.

---
 rtl/uart_program_loader.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_program_loader.sv
// uart_program_loader: assembles UART bytes into instruction words, writes them
// sequentially into instruction memory, stops on a HALT opcode or a full memory,
// and reports each written word index back through the UART transmitter.
module uart_program_loader #(
    parameter int                DATA_WIDTH      = 32,
    parameter int                DATA_WIDTH_UART = 8,
    parameter int                ADDR_WIDTH      = 5,
    parameter int                SIZEOP          = 6,
    parameter logic [SIZEOP-1:0] HALT_OPCODE     = 6'b111111,
    parameter int                MSB_FIRST       = 0,
    parameter int                TIMEOUT_CYCLES  = 4096,
    parameter int                ECHO_EN         = 1
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic [DATA_WIDTH_UART-1:0] i_rx_byte,
    input  logic                       i_rx_done,
    input  logic                       i_tx_available,
    input  logic                       i_restart,
    output logic [DATA_WIDTH_UART-1:0] o_tx_byte,
    output logic                       o_tx_signal,
    output logic                       o_wr_en,
    output logic [ADDR_WIDTH-1:0]      o_wr_addr,
    output logic [DATA_WIDTH-1:0]      o_wr_data,
    output logic [ADDR_WIDTH:0]        o_word_count,
    output logic                       o_load_done,
    output logic                       o_overflow,
    output logic                       o_frame_err
);

    localparam int BPW   = DATA_WIDTH / DATA_WIDTH_UART;
    localparam int BC_W  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W = ADDR_WIDTH + 1;

    localparam logic [BC_W-1:0]       LAST_POS  = BC_W'(BPW - 1);
    localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
    // Position reached after byte 0 has been stored (wraps to 0 for one-byte words)
    localparam logic [BC_W-1:0]       POS_ONE   = (BPW > 1) ? BC_W'(1) : '0;

    typedef enum logic [1:0] {IDLE, ASSEMBLE, WRITE, DONE} state_t;

    state_t                     state_q, state_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [BC_W-1:0]            byte_cnt_q, byte_cnt_d;
    logic [DATA_WIDTH-1:0]      word_q, word_d;
    logic [TMO_W-1:0]           tmo_q, tmo_d;
    logic                       done_q, done_d;
    logic                       ovf_q, ovf_d;
    logic                       ferr_q, ferr_d;
    logic                       ack_pend_q, ack_pend_d;
    logic [DATA_WIDTH_UART-1:0] ack_val_q, ack_val_d;
    logic [DATA_WIDTH_UART-1:0] tx_byte_q, tx_byte_d;
    logic                       tx_sig_q, tx_sig_d;
    logic                       is_halt;

    // Drop a byte into word w at byte position pos, honouring the byte order
    function automatic logic [DATA_WIDTH-1:0] place_byte(
        input logic [DATA_WIDTH-1:0]      w,
        input logic [BC_W-1:0]            pos,
        input logic [DATA_WIDTH_UART-1:0] b
    );
        logic [DATA_WIDTH-1:0] r;
        int                    lo;
        r = w;
        if (MSB_FIRST != 0) lo = DATA_WIDTH - DATA_WIDTH_UART * (int'(pos) + 1);
        else                lo = DATA_WIDTH_UART * int'(pos);
        r[lo +: DATA_WIDTH_UART] = b;
        return r;
    endfunction

    assign is_halt = (word_q[DATA_WIDTH-1 -: SIZEOP] == HALT_OPCODE);

    // FSM state register
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Datapath, counters, flags and acknowledge registers
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            addr_q     <= '0;
            cnt_q      <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            tmo_q      <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            ferr_q     <= 1'b0;
            ack_pend_q <= 1'b0;
            ack_val_q  <= '0;
            tx_byte_q  <= '0;
            tx_sig_q   <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            tmo_q      <= tmo_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            ferr_q     <= ferr_d;
            ack_pend_q <= ack_pend_d;
            ack_val_q  <= ack_val_d;
            tx_byte_q  <= tx_byte_d;
            tx_sig_q   <= tx_sig_d;
        end
    end

    // Next-state logic: byte assembly, write, timeout, acknowledge and restart
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        tmo_d      = tmo_q;
        done_d     = done_q;
        ovf_d      = ovf_q;
        ferr_d     = 1'b0;
        ack_pend_d = ack_pend_q;
        ack_val_d  = ack_val_q;
        tx_byte_d  = tx_byte_q;
        tx_sig_d   = 1'b0;

        // Hand the pending ack to the transmitter as soon as it is idle
        if (ack_pend_q && i_tx_available) begin
            tx_sig_d   = 1'b1;
            tx_byte_d  = ack_val_q;
            ack_pend_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (i_rx_done) begin
                    word_d     = place_byte('0, '0, i_rx_byte);
                    byte_cnt_d = POS_ONE;
                    tmo_d      = '0;
                    state_d    = (BPW == 1) ? WRITE : ASSEMBLE;
                end
            end
            ASSEMBLE: begin
                // A byte arriving on the expiry cycle wins over the timeout
                if (i_rx_done) begin
                    word_d = place_byte(word_q, byte_cnt_q, i_rx_byte);
                    tmo_d  = '0;
                    if (byte_cnt_q == LAST_POS) begin
                        byte_cnt_d = '0;
                        state_d    = WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BC_W'(1);
                    end
                end else if (tmo_q == TMO_LAST) begin
                    ferr_d     = 1'b1;
                    word_d     = '0;
                    byte_cnt_d = '0;
                    tmo_d      = '0;
                    state_d    = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            WRITE: begin
                addr_d     = addr_q + ADDR_WIDTH'(1);
                cnt_d      = cnt_q + CNT_W'(1);
                ack_pend_d = (ECHO_EN != 0);
                ack_val_d  = DATA_WIDTH_UART'(addr_q);
                if (is_halt) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (addr_q == ADDR_LAST) begin
                    done_d  = 1'b1;
                    ovf_d   = 1'b1;
                    state_d = DONE;
                end else if (i_rx_done) begin
                    // Back-to-back byte becomes byte 0 of the next word
                    word_d     = place_byte('0, '0, i_rx_byte);
                    byte_cnt_d = POS_ONE;
                    tmo_d      = '0;
                    state_d    = (BPW == 1) ? WRITE : ASSEMBLE;
                end else begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        if (i_restart) begin
            state_d    = IDLE;
            addr_d     = '0;
            cnt_d      = '0;
            byte_cnt_d = '0;
            word_d     = '0;
            tmo_d      = '0;
            done_d     = 1'b0;
            ovf_d      = 1'b0;
            ferr_d     = 1'b0;
            ack_pend_d = 1'b0;
            tx_sig_d   = 1'b0;
        end
    end

    assign o_wr_en      = (state_q == WRITE);
    assign o_wr_addr    = addr_q;
    assign o_wr_data    = word_q;
    assign o_word_count = cnt_q;
    assign o_load_done  = done_q;
    assign o_overflow   = ovf_q;
    assign o_frame_err  = ferr_q;
    assign o_tx_byte    = tx_byte_q;
    assign o_tx_signal  = tx_sig_q;

endmodule
